// File: rtl/sobel_row_sequencer.sv
// Strip-by-strip row sequencer for the Sobel core: generates read/write addresses
// and handshakes, one row read then one NUM_ACC-byte result write per output row.
module sobel_row_sequencer #(
  parameter int NUM_ACC    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic [DIM_WIDTH-1:0]  img_cols,
  input  logic [DIM_WIDTH-1:0]  img_rows,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  output logic                  srow_shift,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CALC, S_WR, S_NEXT, S_DONE
  } state_t;

  localparam logic [DIM_WIDTH-1:0] STRIP_W = DIM_WIDTH'(NUM_ACC + 2);
  localparam logic [DIM_WIDTH-1:0] STEP    = DIM_WIDTH'(NUM_ACC);
  localparam logic [DIM_WIDTH-1:0] TWO     = DIM_WIDTH'(2);
  localparam logic [DIM_WIDTH-1:0] THREE   = DIM_WIDTH'(3);

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  cols_q, cols_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d;
  logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
  logic [ADDR_WIDTH-1:0] out_base_q, out_base_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [DIM_WIDTH-1:0]  rows_loaded_q, rows_loaded_d;
  logic [ADDR_WIDTH-1:0] row_off_q, row_off_d;
  logic [ADDR_WIDTH-1:0] wr_off_q, wr_off_d;
  logic                  err_q, err_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DIM_WIDTH-1:0]  col_step, col_last;

  // Next strip start, clamped so the final strip ends exactly on the right edge
  assign col_step = col_q + STEP;
  assign col_last = cols_q - STRIP_W;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cols_q        <= '0;
      rows_q        <= '0;
      in_base_q     <= '0;
      out_base_q    <= '0;
      col_q         <= '0;
      rows_loaded_q <= '0;
      row_off_q     <= '0;
      wr_off_q      <= '0;
      err_q         <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      cols_q        <= cols_d;
      rows_q        <= rows_d;
      in_base_q     <= in_base_d;
      out_base_q    <= out_base_d;
      col_q         <= col_d;
      rows_loaded_q <= rows_loaded_d;
      row_off_q     <= row_off_d;
      wr_off_q      <= wr_off_d;
      err_q         <= err_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      wr_req_q      <= wr_req_d;
      wr_addr_q     <= wr_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cols_d        = cols_q;
    rows_d        = rows_q;
    in_base_d     = in_base_q;
    out_base_d    = out_base_q;
    col_d         = col_q;
    rows_loaded_d = rows_loaded_q;
    row_off_d     = row_off_q;
    wr_off_d      = wr_off_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          cols_d        = img_cols;
          rows_d        = img_rows;
          in_base_d     = in_base;
          out_base_d    = out_base;
          col_d         = '0;
          rows_loaded_d = '0;
          row_off_d     = '0;
          wr_off_d      = '0;
          if (img_cols < STRIP_W || img_rows < THREE) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (rd_ack) begin
          rows_loaded_d = rows_loaded_q + 1'b1;
          row_off_d     = row_off_q + ADDR_WIDTH'(cols_q);
          // Write offset trails the read offset by three rows
          if (rows_loaded_q >= THREE) begin
            wr_off_d = wr_off_q + ADDR_WIDTH'(cols_q);
          end
          if (rows_loaded_q >= TWO) begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: state_d = S_WR;
      S_WR: begin
        if (wr_ack) begin
          state_d = (rows_loaded_q == rows_q) ? S_NEXT : S_RD;
        end
      end
      S_NEXT: begin
        if (col_q + STRIP_W == cols_q) begin
          state_d = S_DONE;
        end else begin
          col_d         = (col_step > col_last) ? col_last : col_step;
          rows_loaded_d = '0;
          row_off_d     = '0;
          wr_off_d      = '0;
          state_d       = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_req_d   = (state_d == S_RD);
    rd_addr_d  = rd_req_d ? (in_base_d + row_off_d + ADDR_WIDTH'(col_d)) : '0;
    wr_req_d   = (state_d == S_WR);
    wr_addr_d  = wr_req_d ? (out_base_d + wr_off_d + ADDR_WIDTH'(col_d) + ADDR_WIDTH'(1)) : '0;
    rd_req     = rd_req_q;
    rd_addr    = rd_addr_q;
    wr_req     = wr_req_q;
    wr_addr    = wr_addr_q;
    srow_shift = (state_q == S_RD) && rd_ack;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    cfg_err    = (state_q == S_DONE) && err_q;
  end

endmodule

// File: tb/tb_sobel_row_sequencer.sv
// Bench for sobel_row_sequencer: a transaction-list model of the strip walk is
// compared against every read/write handshake, plus handshake/pulse rules.
module tb_sobel_row_sequencer;
  localparam int NA = 8;
  localparam int AW = 32;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic [DW-1:0] img_cols = '0, img_rows = '0;
  logic [AW-1:0] in_base = '0, out_base = '0;
  logic          rd_ack = 1'b0, wr_ack = 1'b0;
  logic          rd_req, wr_req, srow_shift, busy, done, cfg_err;
  logic [AW-1:0] rd_addr, wr_addr;

  sobel_row_sequencer #(.NUM_ACC(NA), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .img_cols(img_cols), .img_rows(img_rows), .in_base(in_base), .out_base(out_base),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .srow_shift(srow_shift),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
  } txn_t;

  txn_t          exp_q[$];
  logic [AW-1:0] wr_log[$];
  logic [AW-1:0] rd_log[$];
  int            exp_rd = 0;
  int            checks = 0, passes = 0;
  int            cyc = 0, go_cyc = 0;
  int            done_count = 0, req_cycles = 0;
  int            ack_mode = 0;
  bit            exp_err = 1'b0, timed_chk = 1'b0;
  int            exp_lat = 0;
  bit            rd_fire = 1'b0, wr_fire = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Whole-frame transaction list: each strip reads every row, and each row from
  // the third on produces the write for the row above it.
  task automatic model(input int c, input int r, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                       output int strips);
    int col;
    col = 0;
    strips = 0;
    forever begin
      for (int row = 0; row < r; row++) begin
        exp_q.push_back('{1'b0, ib + AW'(row * c + col)});
        if (row >= 2) exp_q.push_back('{1'b1, ob + AW'((row - 2) * c + col + 1)});
      end
      strips++;
      if (col + NA + 2 == c) break;
      col = (col + NA < c - NA - 2) ? col + NA : c - NA - 2;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ack responder: mode 0 tied high, mode 1 fixed stalls, mode 2 random (incl. spurious)
  int rd_wait = 0, wr_wait = 0;
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      rd_wait = 0;
      wr_wait = 0;
    end else begin
      if (rd_fire || !rd_req) rd_wait = 0;
      if (wr_fire || !wr_req) wr_wait = 0;
      if (rd_req) rd_wait++;
      if (wr_req) wr_wait++;
    end
    case (ack_mode)
      0: begin rd_ack = 1'b1; wr_ack = 1'b1; end
      1: begin rd_ack = (rd_wait >= 4); wr_ack = (wr_wait >= 3); end
      default: begin
        rd_ack = ($urandom_range(0, 2) == 0);
        wr_ack = ($urandom_range(0, 2) == 0);
      end
    endcase
  end

  // Per-cycle compare against the model and the handshake rules
  bit            rd_pend = 1'b0, wr_pend = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] rd_pend_addr = '0, wr_pend_addr = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      rd_pend = 1'b0; wr_pend = 1'b0; rd_fire = 1'b0; wr_fire = 1'b0; prev_done = 1'b0;
      exp_rd = exp_q.size();
    end else begin
      if (rd_req || wr_req) req_cycles++;
      check("req_exclusive", 64'(rd_req & wr_req), 64'd0);
      check("srow_shift", 64'(srow_shift), 64'(rd_req & rd_ack));
      check("cfg_err_without_done", 64'(cfg_err & ~done), 64'd0);
      if (rd_pend) check("rd_hold", {31'd0, rd_req, rd_addr}, {31'd0, 1'b1, rd_pend_addr});
      if (wr_pend) check("wr_hold", {31'd0, wr_req, wr_addr}, {31'd0, 1'b1, wr_pend_addr});
      if (prev_done) check("done_single_pulse", {61'd0, done, busy, cfg_err}, 64'd0);
      rd_fire = rd_req && rd_ack;
      wr_fire = wr_req && wr_ack;
      if (rd_fire || wr_fire) begin
        if (exp_rd >= exp_q.size()) begin
          check("unexpected_txn", {31'd0, wr_fire, rd_fire ? rd_addr : wr_addr}, 64'd0);
        end else begin
          check(wr_fire ? "wr_seq" : "rd_seq", {31'd0, wr_fire, rd_fire ? rd_addr : wr_addr},
                {31'd0, exp_q[exp_rd]});
          exp_rd++;
        end
        $display("cyc %0d %s addr=0x%08h", cyc, wr_fire ? "WR" : "RD", rd_fire ? rd_addr : wr_addr);
        if (wr_fire) wr_log.push_back(wr_addr);
        if (rd_fire) rd_log.push_back(rd_addr);
      end
      rd_pend = rd_req && !rd_ack; rd_pend_addr = rd_addr;
      wr_pend = wr_req && !wr_ack; wr_pend_addr = wr_addr;
      if (done) begin
        done_count++;
        check("all_txns_before_done", 64'(exp_rd), 64'(exp_q.size()));
        check("cfg_err", 64'(cfg_err), 64'(exp_err));
        if (timed_chk) check("done_latency", 64'(cyc - go_cyc), 64'(exp_lat));
        if (exp_err) check("err_latency_le2", 64'((cyc - go_cyc) <= 2), 64'd1);
        $display("cyc %0d DONE cfg_err=%0d latency=%0d", cyc, cfg_err, cyc - go_cyc);
      end
      prev_done = done;
    end
  end

  int done_base = 0, req_base = 0, wr_base = 0, rd_base = 0;

  task automatic launch(input int c, input int r, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                        input bit timed, input int mode, output int strips, output int base);
    bit err;
    err = (c < NA + 2) || (r < 3);
    base = exp_q.size();
    strips = 0;
    if (!err) model(c, r, ib, ob, strips);
    ack_mode = mode;
    exp_err = err;
    timed_chk = timed && !err;
    exp_lat = strips * (3 * r - 3) + 1;
    done_base = done_count; req_base = req_cycles; wr_base = wr_log.size(); rd_base = rd_log.size();
    @(posedge clk); #2;
    img_cols = DW'(c); img_rows = DW'(r); in_base = ib; out_base = ob;
    go = 1'b1; go_cyc = cyc;
    @(negedge clk);
    check("busy_before_go", 64'(busy), 64'd0);
    @(posedge clk); #2;
    go = 1'b0;
    img_cols = DW'($urandom); img_rows = DW'($urandom); in_base = $urandom; out_base = $urandom;
    @(negedge clk);
    check("busy_after_go", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input bit spur);
    int n;
    n = 0;
    while (done_count == done_base && n < 20000) begin
      @(negedge clk);
      go = 1'b0;
      n++;
      if (spur && busy && !done && $urandom_range(0, 19) == 0) begin
        go = 1'b1;
        img_cols = DW'($urandom_range(10, 40)); img_rows = DW'($urandom_range(3, 9));
      end
    end
    go = 1'b0;
    check("done_seen_once", 64'(done_count - done_base), 64'd1);
    @(negedge clk);
    if (exp_err) check("no_req_on_cfg_err", 64'(req_cycles - req_base), 64'd0);
  endtask

  initial begin
    int s, b, n, c, r;
    logic [AW-1:0] ref_wr[$];
    logic [AW-1:0] wlit[6];
    #12;
    check("reset_flags", {58'd0, rd_req, wr_req, srow_shift, busy, done, cfg_err}, 64'd0);
    check("reset_addrs", 64'(rd_addr | wr_addr), 64'd0);
    @(posedge clk); #2; reset_n = 1'b1;

    // Single strip, acks tied high
    launch(10, 3, 32'h100, 32'h800, 1'b1, 0, s, b);
    check("m1_strips", 64'(s), 64'd1);
    check("m1_lat", 64'(exp_lat), 64'd7);
    check("m1_rd0", 64'(exp_q[b].addr), 64'h100);
    check("m1_rd1", 64'(exp_q[b+1].addr), 64'h10A);
    check("m1_rd2", 64'(exp_q[b+2].addr), 64'h114);
    check("m1_wr0", {31'd0, exp_q[b+3]}, {31'd0, 1'b1, 32'h801});
    wait_done(1'b0);

    // Clamped last strip
    wlit = '{32'd1, 32'd21, 32'd9, 32'd29, 32'd11, 32'd31};
    launch(20, 4, 32'h0, 32'h0, 1'b1, 0, s, b);
    check("m2_strips", 64'(s), 64'd3);
    n = 0;
    for (int i = b; i < exp_q.size(); i++) begin
      if (exp_q[i].is_wr) begin
        if (n < 6) check("m2_wr_lit", 64'(exp_q[i].addr), 64'(wlit[n]));
        n++;
      end
    end
    check("m2_wr_count", 64'(n), 64'd6);
    wait_done(1'b0);
    for (int i = wr_base; i < wr_log.size(); i++) ref_wr.push_back(wr_log[i]);

    // Same frame under fixed read/write stalls
    launch(20, 4, 32'h0, 32'h0, 1'b0, 1, s, b);
    wait_done(1'b0);
    check("stall_wr_count", 64'(wr_log.size() - wr_base), 64'(ref_wr.size()));
    for (int i = 0; i < ref_wr.size() && wr_base + i < wr_log.size(); i++)
      check("stall_wr_same", 64'(wr_log[wr_base+i]), 64'(ref_wr[i]));

    // Rejected configurations
    launch(9, 5, 32'h40, 32'h80, 1'b0, 0, s, b);
    wait_done(1'b0);
    launch(10, 2, 32'h40, 32'h80, 1'b0, 0, s, b);
    wait_done(1'b0);

    // Reset during a write of the second strip
    launch(20, 4, 32'h0, 32'h0, 1'b0, 1, s, b);
    n = 0;
    while (!(wr_req && !wr_ack && (wr_log.size() - wr_base) >= 2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_strip2_wr", 64'(n < 2000), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_flags", {58'd0, rd_req, wr_req, srow_shift, busy, done, cfg_err}, 64'd0);
    check("midrst_addrs", 64'(rd_addr | wr_addr), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b1;
    launch(20, 4, 32'h4000, 32'h9000, 1'b1, 0, s, b);
    wait_done(1'b0);
    if (rd_log.size() > rd_base) check("restart_first_rd", 64'(rd_log[rd_base]), 64'h4000);
    else check("restart_first_rd_missing", 64'd0, 64'd1);

    // Randomized frames with stalls, spurious acks and spurious go pulses
    for (int f = 0; f < 16; f++) begin
      c = (f < 3) ? (10 + f * 4) : $urandom_range(10, 50);
      r = (f == 0) ? 3 : $urandom_range(3, 8);
      launch(c, r, (f % 4 == 0) ? (32'hFFFF_FF00 + 32'($urandom_range(0, 255))) : $urandom,
             $urandom, 1'b0, (f % 2 == 0) ? 2 : 1, s, b);
      wait_done(1'b1);
    end
    // One more timed frame after random traffic, with a non-multiple width
    launch(27, 5, 32'h1234, 32'h5678, 1'b1, 0, s, b);
    wait_done(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
